// File: rtl/downsample_engine.sv
// downsample_engine: reads an image from memory and writes it back reduced by F = 2^FACTOR_LOG2,
// either keeping the top-left pixel of each FxF block or writing the block average.
module downsample_engine #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 16,
   parameter int FACTOR_LOG2 = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [ADDR_W-1:0] img_w,
   input  logic [ADDR_W-1:0] img_h,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] dout,
   output logic              read,
   output logic              write,
   output logic              busy,
   output logic              finish
);
   localparam int F  = 1 << FACTOR_LOG2;
   localparam int CW = FACTOR_LOG2 + 1;
   localparam int AW = DATA_W + 2 * FACTOR_LOG2;
   localparam logic [CW-1:0]     SUB_LAST = CW'(F - 1);
   localparam logic [CW-1:0]     C_ONE    = CW'(1);
   localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              finish_q, finish_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, w_q, w_d, ow_q, ow_d, oh_q, oh_d;
   logic [ADDR_W-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [CW-1:0]     i_q, i_d, j_q, j_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [ADDR_W-1:0] rd_row, rd_addr, wr_addr, new_ow, new_oh;
   logic [DATA_W-1:0] res;
   logic              blk_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         finish_q <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         w_q      <= '0;
         ow_q     <= '0;
         oh_q     <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         i_q      <= '0;
         j_q      <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         finish_q <= finish_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         w_q      <= w_d;
         ow_q     <= ow_d;
         oh_q     <= oh_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         i_q      <= i_d;
         j_q      <= j_d;
         acc_q    <= acc_d;
      end
   end

   // all address arithmetic deliberately wraps at ADDR_W bits
   always_comb begin
      rd_row   = (oy_q << FACTOR_LOG2) + ADDR_W'(i_q);
      rd_addr  = src_q + rd_row * w_q + (ox_q << FACTOR_LOG2) + ADDR_W'(j_q);
      wr_addr  = dst_q + oy_q * ow_q + ox_q;
      res      = mode_q ? DATA_W'(acc_q >> (2 * FACTOR_LOG2)) : DATA_W'(acc_q);
      blk_last = !mode_q || (i_q == SUB_LAST && j_q == SUB_LAST);
      new_ow   = img_w >> FACTOR_LOG2;
      new_oh   = img_h >> FACTOR_LOG2;
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      finish_d = finish_q;
      src_d    = src_q;
      dst_d    = dst_q;
      w_d      = w_q;
      ow_d     = ow_q;
      oh_d     = oh_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      i_d      = i_q;
      j_d      = j_q;
      acc_d    = acc_q;
      read     = 1'b0;
      write    = 1'b0;
      addr_out = '0;
      dout     = '0;
      case (state_q)
         IDLE: if (enable) begin
            mode_d   = mode;
            src_d    = src_base;
            dst_d    = dst_base;
            w_d      = img_w;
            ow_d     = new_ow;
            oh_d     = new_oh;
            ox_d     = '0;
            oy_d     = '0;
            i_d      = '0;
            j_d      = '0;
            acc_d    = '0;
            finish_d = 1'b0;
            state_d  = (new_ow == '0 || new_oh == '0) ? DONE : RD;
         end
         RD: begin
            read     = 1'b1;
            addr_out = rd_addr;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            acc_d   = acc_q + AW'(din);
            state_d = blk_last ? WR : RD;
            i_d     = blk_last ? '0 : (j_q == SUB_LAST ? i_q + C_ONE : i_q);
            j_d     = (blk_last || j_q == SUB_LAST) ? '0 : j_q + C_ONE;
         end
         WR: begin
            write    = 1'b1;
            addr_out = wr_addr;
            dout     = res;
            acc_d    = '0;
            ox_d     = (ox_q == ow_q - A_ONE) ? '0 : ox_q + A_ONE;
            oy_d     = (ox_q == ow_q - A_ONE) ? oy_q + A_ONE : oy_q;
            state_d  = (ox_q == ow_q - A_ONE && oy_q == oh_q - A_ONE) ? DONE : RD;
         end
         DONE: begin
            finish_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q == RD) || (state_q == RD_WAIT) || (state_q == WR);
   assign finish = finish_q;

endmodule

// File: tb/tb_downsample_engine.sv
// tb_downsample_engine: drives jobs into downsample_engine against a byte memory and compares
// strobes, addresses, data and timing with a loop-based reference of the downsampling rules.
module tb_downsample_engine;
   localparam int FL = 1;
   localparam int F  = 2;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0;
   logic [15:0] src_base = '0, dst_base = '0, img_w = '0, img_h = '0;
   logic [7:0]  din = '0;
   logic [15:0] addr_out;
   logic [7:0]  dout;
   logic        read, write, busy, finish;

   logic [7:0]  mem [0:65535];
   int          rd_addrs[$], wr_addrs[$], wr_data[$];
   int          busy_cyc, viol;
   int          checks = 0, failures = 0;

   downsample_engine #(.DATA_W(8), .ADDR_W(16), .FACTOR_LOG2(FL)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .src_base(src_base), .dst_base(dst_base), .img_w(img_w), .img_h(img_h),
      .din(din), .addr_out(addr_out), .dout(dout), .read(read), .write(write),
      .busy(busy), .finish(finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) din <= read ? mem[addr_out] : 8'd0;

   always @(negedge clk) begin
      if (read) rd_addrs.push_back(int'(addr_out));
      if (write) begin
         wr_addrs.push_back(int'(addr_out));
         wr_data.push_back(int'(dout));
      end
      if (busy) busy_cyc++;
      if ((read && write) || (!read && !write && (addr_out != 0 || dout != 0))) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rd_addrs.delete();
      wr_addrs.delete();
      wr_data.delete();
      busy_cyc = 0;
      viol = 0;
   endtask

   task automatic run_job(input string tag, input logic m, input logic [15:0] sb, db, w, h,
                          input bit disturb);
      int ow, oh, nb, sum, a, cyc, first_rd, fin_cyc;
      int er[$], ea[$], ed[$];
      ow = int'(w) >> FL;
      oh = int'(h) >> FL;
      nb = m ? F : 1;
      for (int y = 0; y < oh; y++)
         for (int x = 0; x < ow; x++) begin
            sum = 0;
            for (int i = 0; i < nb; i++)
               for (int j = 0; j < nb; j++) begin
                  a = (int'(sb) + (y * F + i) * int'(w) + x * F + j) & 16'hFFFF;
                  er.push_back(a);
                  sum += int'(mem[a]);
               end
            ea.push_back((int'(db) + y * ow + x) & 16'hFFFF);
            ed.push_back(m ? sum / (F * F) : sum);
         end
      @(posedge clk); #1;
      clear_mon();
      mode = m; src_base = sb; dst_base = db; img_w = w; img_h = h; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      mode = ~m; src_base = 16'($urandom); dst_base = 16'($urandom);
      img_w = 16'($urandom); img_h = 16'($urandom);
      cyc = 0; first_rd = -1; fin_cyc = -1;
      while (cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (read && first_rd < 0) first_rd = cyc;
         if (finish) begin
            fin_cyc = cyc;
            break;
         end
         if (disturb && cyc == 4) enable = 1'b1;
         if (disturb && cyc == 5) enable = 1'b0;
      end
      #1;
      check({tag, "_finished"}, fin_cyc >= 0, 1);
      check({tag, "_nreads"}, rd_addrs.size(), er.size());
      check({tag, "_nwrites"}, wr_addrs.size(), ea.size());
      for (int k = 0; k < er.size() && k < rd_addrs.size(); k++)
         check($sformatf("%s_rdaddr%0d", tag, k), rd_addrs[k], er[k]);
      for (int k = 0; k < ea.size() && k < wr_addrs.size(); k++) begin
         check($sformatf("%s_wraddr%0d", tag, k), wr_addrs[k], ea[k]);
         check($sformatf("%s_wrdata%0d", tag, k), wr_data[k], ed[k]);
      end
      check({tag, "_busy_cycles"}, busy_cyc, ea.size() * (m ? 2 * F * F + 1 : 3));
      check({tag, "_strobe_rules"}, viol, 0);
      if (ea.size() > 0) begin
         check({tag, "_first_read_cycle"}, first_rd, 1);
         check({tag, "_finish_cycle"}, fin_cyc, busy_cyc + 2);
      end else
         check({tag, "_finish_cycle"}, fin_cyc, 2);
      check({tag, "_busy_low_at_end"}, busy, 0);
   endtask

   initial begin
      int exp_avg[4], exp_dec[4], n, guard;
      logic [7:0] img[16];
      exp_avg = '{25, 45, 2, 8};
      exp_dec = '{10, 30, 0, 8};
      img = '{10, 20, 30, 40, 30, 40, 50, 60, 0, 0, 8, 8, 4, 4, 8, 8};
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) mem[16'h0100 + i] = img[i];
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      check("rst_read", read, 0);
      check("rst_write", write, 0);
      check("rst_busy", busy, 0);
      check("rst_finish", finish, 0);
      check("rst_addr", addr_out, 0);
      check("rst_dout", dout, 0);
      rst_n = 1'b1;

      run_job("avg4x4", 1'b1, 16'h0100, 16'h0200, 16'd4, 16'd4, 1'b0);
      for (int k = 0; k < 4; k++)
         check($sformatf("avg4x4_value%0d", k), k < wr_data.size() ? wr_data[k] : -1, exp_avg[k]);
      check("avg4x4_job_cycles", busy_cyc, 36);

      run_job("dec4x4", 1'b0, 16'h0100, 16'h0200, 16'd4, 16'd4, 1'b0);
      for (int k = 0; k < 4; k++)
         check($sformatf("dec4x4_value%0d", k), k < wr_data.size() ? wr_data[k] : -1, exp_dec[k]);
      check("dec4x4_job_cycles", busy_cyc, 12);
      check("dec4x4_reads", rd_addrs.size(), 4);

      run_job("empty3x1", 1'b1, 16'h0100, 16'h0200, 16'd3, 16'd1, 1'b0);
      check("empty3x1_no_strobes", rd_addrs.size() + wr_addrs.size(), 0);

      run_job("wrap", 1'b1, 16'hFFFE, 16'h0300, 16'd2, 16'd2, 1'b0);
      check("wrap_rd3", rd_addrs.size() > 2 ? rd_addrs[2] : -1, 0);
      check("wrap_writes", wr_addrs.size(), 1);

      run_job("ignore_en", 1'b1, 16'h0100, 16'h0200, 16'd4, 16'd4, 1'b1);

      @(posedge clk); #1;
      mode = 1'b1; src_base = 16'h0100; dst_base = 16'h0200; img_w = 16'd4; img_h = 16'd4;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      n = 0; guard = 0;
      while (n < 3 && guard < 100) begin
         @(posedge clk); #2;
         guard++;
         if (read) n++;
      end
      check("rst_third_rd_seen", n, 3);
      rst_n = 1'b0;
      #1;
      check("midrst_read", read, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", addr_out, 0);
      check("midrst_finish", finish, 0);
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_strobes", rd_addrs.size() + wr_addrs.size(), 0);
      check("post_rst_busy", busy_cyc, 0);
      check("post_rst_finish", finish, 0);

      for (int t = 0; t < 12; t++)
         run_job($sformatf("rand%0d", t), 1'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom_range(0, 9)), 16'($urandom_range(0, 9)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/downsample_engine.md
DOWNSAMPLE_ENGINE -- requirements
Module: downsample_engine

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter ADDR_W, default 16, memory address width in bits.
REQ-003 Parameter FACTOR_LOG2, default 1, sets the decimation factor F = 2^FACTOR_LOG2 (legal range 0..3).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 enable  input  1  start request; sampled only in IDLE.
REQ-007 mode  input  1  0 = decimate (keep top-left pixel of each FxF block), 1 = box-average; sampled with enable.
REQ-008 src_base, dst_base  input  ADDR_W each  source image base address and destination image base address; sampled with enable.
REQ-009 img_w, img_h  input  ADDR_W each  source width and height in pixels; sampled with enable.
REQ-010 din  input  DATA_W  memory read data, valid the cycle after read is asserted.
REQ-011 addr_out  output  ADDR_W  memory address for read or write.
REQ-012 dout  output  DATA_W  memory write data.
REQ-013 read, write  output  1 each  memory strobes; never both high in the same cycle.
REQ-014 busy  output  1  high from the cycle after enable is accepted until DONE.
REQ-015 finish  output  1  job complete; held high until the next accepted enable or reset.

Function
REQ-016 FSM states SHALL be IDLE, RD, RD_WAIT, WR and DONE.
REQ-017 IDLE with enable=1 SHALL latch the config, clear finish, clear the counters and the accumulator, and go to RD.
REQ-018 Output grid: OW = img_w >> FACTOR_LOG2 and OH = img_h >> FACTOR_LOG2; leftover source columns and rows SHALL be ignored.
REQ-019 If OW=0 or OH=0, the block SHALL go IDLE->DONE with no read or write strobe.
REQ-020 Output pixels SHALL be processed in raster order (ox fastest), with counters ox, oy, and the sub-block counters i (row) and j (column).
REQ-021 RD SHALL drive read=1 and addr_out = src_base + (oy*F+i)*img_w + ox*F + j, for exactly one cycle, then go to RD_WAIT.
REQ-022 RD_WAIT SHALL add din, zero-extended, to an accumulator of width DATA_W+2*FACTOR_LOG2.
REQ-023 From RD_WAIT, the FSM SHALL go to RD for the next (i,j) until the block is complete, then go to WR.
REQ-024 In decimate mode, the block SHALL contain only i=j=0: one read per output pixel.
REQ-025 In average mode, the block SHALL contain i,j in 0..F-1 with j fastest, giving F*F reads.
REQ-026 WR SHALL drive write=1, addr_out = dst_base + oy*OW + ox and dout for exactly one cycle.
REQ-027 dout SHALL be the accumulator in decimate mode, and accumulator >> (2*FACTOR_LOG2) (truncating) in average mode.
REQ-028 After WR, the accumulator SHALL be cleared and ox incremented; at ox=OW-1, ox SHALL wrap to 0 and oy increment.
REQ-029 After WR of the last pixel (ox=OW-1, oy=OH-1), the FSM SHALL go to DONE.
REQ-030 Throughput SHALL be 3 cycles per output pixel in decimate mode and 2*F*F+1 cycles in average mode.
REQ-031 The first read SHALL occur in the cycle after enable is sampled.
REQ-032 All address arithmetic SHALL be modulo 2^ADDR_W; wrap-around is legal and SHALL NOT be flagged.
REQ-033 DONE SHALL assert finish, drop busy and return to IDLE the next cycle; finish SHALL stay high.
REQ-034 enable and config changes while busy SHALL be ignored and SHALL NOT affect the running job.
REQ-035 With FACTOR_LOG2=0, both modes SHALL perform a plain copy.
REQ-036 addr_out and dout SHALL be 0 whenever read=0 and write=0.

Reset
REQ-037 rst_n=0 SHALL, at any time and asynchronously, force IDLE and clear every output, counter and the accumulator.
REQ-038 A job interrupted by reset SHALL NOT resume, and no further strobe SHALL be issued until a new enable.

Verification
REQ-039 F=2, average, 4x4 image at src_base=0x0100 with rows {10,20,30,40},{30,40,50,60},{0,0,8,8},{4,4,8,8}, dst_base=0x0200 -> writes 0x0200=25, 0x0201=45, 0x0202=2, 0x0203=8; 4*9=36 cycles from first read to finish.
REQ-040 Same image, decimate -> writes 10, 30, 0, 8 to 0x0200..0x0203; 12 cycles; exactly 4 reads.
REQ-041 img_w=3, img_h=1, F=2 -> finish one cycle after DONE entry; zero read and write strobes.
REQ-042 src_base=0xFFFE, 2x2 image, average -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001; one write.
REQ-043 rst_n pulsed low during the third RD of a job -> all outputs 0 immediately; IDLE; no strobes until a new enable.
REQ-044 enable pulsed while busy with a new dst_base -> ignored; the original addresses are used throughout.
